control_fifo_arb: RTL and testbench
===================================

CONTROL_FIFO_ARB -- requirements
Module: control_fifo_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of byte-stream requesters (2..8).
REQ-002 Parameter BURST_BYTES, default 32: bytes per grant, equal to one 256-bit FIFO read word.
REQ-003 Parameter START_MAX_LEVEL, default 2016: highest FIFO write level at which a new burst may start.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  arbitration enable; low blocks new grants, and an in-flight burst still completes.
REQ-007 req  in  N_REQ  per-source request; one bit per source.
REQ-008 src_data  in  8*N_REQ  source bytes, packed flat; source i occupies bits [8i+7:8i].
REQ-009 src_vld  in  N_REQ  per-source byte valid.
REQ-010 src_rdy  out  N_REQ  per-source byte ready.
REQ-011 dout  out  8  byte to the packing FIFO's write side.
REQ-012 dout_vld  out  1  write strobe to the packing FIFO.
REQ-013 wr_water_level  in  11  FIFO write-side fill level, in bytes.
REQ-014 almost_full  in  1  FIFO almost-full flag.
REQ-015 grant_id  out  clog2(N_REQ)  source that owns the current or last burst.
REQ-016 busy  out  1  high while in BURST state.
REQ-017 burst_done  out  1  one-cycle pulse after the last byte of a burst is written.

Function
REQ-018 The FSM SHALL have two states: IDLE and BURST.
REQ-019 IDLE->BURST SHALL occur when all of these hold: en=1, req!=0, wr_water_level<=START_MAX_LEVEL, almost_full=0.
REQ-020 On that transition, grant_id SHALL be registered as the first set req bit at or after rr_ptr, searching upward with wrap.
REQ-021 In BURST, src_rdy[grant_id] SHALL equal !almost_full; every other src_rdy bit SHALL be 0.
REQ-022 In IDLE, all src_rdy bits SHALL be 0.
REQ-023 A byte SHALL be accepted when src_vld[grant_id] && src_rdy[grant_id].
REQ-024 An accepted byte SHALL appear on dout with dout_vld=1 exactly one cycle after acceptance (registered, latency 1).
REQ-025 dout_vld SHALL never be asserted in a cycle that follows a cycle with almost_full=1.
REQ-026 A byte counter SHALL count accepted bytes 0..BURST_BYTES-1 and clear on burst end.
REQ-027 The counter SHALL be sized clog2(BURST_BYTES) bits and SHALL never wrap inside a burst.
REQ-028 On acceptance of byte BURST_BYTES-1:
- FSM SHALL return to IDLE;
- rr_ptr SHALL become grant_id+1, modulo N_REQ;
- burst_done SHALL pulse in the same cycle as that byte's dout_vld.
REQ-029 req or src_vld deasserting mid-burst SHALL NOT end the burst; the arbiter holds the grant until BURST_BYTES bytes are accepted, so 256-bit words never mix sources.
REQ-030 en dropping mid-burst SHALL have no effect until the burst ends; the FSM then stays in IDLE.
REQ-031 Leaving BURST and re-granting SHALL take at least one IDLE cycle; back-to-back bursts therefore have a 1-cycle bubble.
REQ-032 A single requester SHALL be re-granted repeatedly whenever it is the only one requesting.
REQ-033 grant_id SHALL hold its value in IDLE.

Reset
REQ-034 While rst_n=0 at a clock edge, the block SHALL load: state=IDLE, rr_ptr=0, counter=0, grant_id=0, dout=0, dout_vld=0, busy=0, burst_done=0.
REQ-035 src_rdy SHALL be 0 in the cycle after reset is sampled.
REQ-036 Reset asserted mid-burst SHALL abort the burst; no partial-burst recovery is provided.

Structure
REQ-037 The shared package SHALL hold: state encoding, BURST_BYTES default, START_MAX_LEVEL default, and the FIFO level width (11).
REQ-038 The round-robin priority pick SHALL be one sub-module, rr_pick: inputs req and rr_ptr; outputs one-hot grant and index.
REQ-039 The FIFO itself SHALL remain outside this block.

Verification
REQ-040 Single source: req=0001, src_data steady 0x00..0x1F with src_vld=1.
-> 32 dout_vld cycles carrying 0x00..0x1F in order, grant_id=0, then a burst_done pulse.
REQ-041 Fairness: req=1111 held for 8 bursts.
-> grant_id sequence 0,1,2,3,0,1,2,3; one IDLE cycle between bursts.
REQ-042 Backpressure: almost_full=1 for cycles 10-14 of a burst.
-> src_rdy[g]=0 during those cycles, no dout_vld, burst completes with exactly 32 bytes.
REQ-043 Level gate: wr_water_level=2017 with req=0010.
-> no grant. Set the level to 2016.
-> BURST begins next cycle.
REQ-044 Stall and enable: src_vld drops for 5 cycles and en drops mid-burst.
-> grant held, 32 bytes total, then FSM stays in IDLE with busy=0.
REQ-045 Reset at byte 17.
-> next cycle all outputs at reset values; after release with req=0100, grant_id=2 and 32 fresh bytes.

Source files
------------

// File: rtl/control_fifo_arb_pkg.sv
// Shared types and defaults for the byte-stream arbiter that feeds a 256-bit packing FIFO.
package control_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int BURST_BYTES_DEF     = 32;
  localparam int START_MAX_LEVEL_DEF = 2016;
  localparam int LEVEL_W             = 11;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/control_fifo_arb_if.sv
// Source-side and FIFO-side signals of the arbiter; master drives requests, slave is the arbiter.
interface control_fifo_arb_if
  import control_fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) ();
  localparam int IW = idx_w(N_REQ);

  logic                 en;
  logic [N_REQ-1:0]     req;
  logic [8*N_REQ-1:0]   src_data;
  logic [N_REQ-1:0]     src_vld;
  logic [N_REQ-1:0]     src_rdy;
  logic [7:0]           dout;
  logic                 dout_vld;
  logic [LEVEL_W-1:0]   wr_water_level;
  logic                 almost_full;
  logic [IW-1:0]        grant_id;
  logic                 busy;
  logic                 burst_done;

  modport master (
    output en, req, src_data, src_vld, wr_water_level, almost_full,
    input  src_rdy, dout, dout_vld, grant_id, busy, burst_done
  );

  modport slave (
    input  en, req, src_data, src_vld, wr_water_level, almost_full,
    output src_rdy, dout, dout_vld, grant_id, busy, burst_done
  );

endinterface

// File: rtl/control_fifo_arb_rr_pick.sv
// Round-robin pick: first set request at or above rr_ptr, wrapping; one-hot and index out.
module control_fifo_arb_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  logic [IW:0]   pos;
  logic [IW-1:0] pos_w;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    pos_w = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // One extra bit holds rr_ptr+k before folding back into range.
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N_REQ)) pos = pos - (IW+1)'(N_REQ);
      pos_w = pos[IW-1:0];
      if (!found && req[pos_w]) begin
        found        = 1'b1;
        grant[pos_w] = 1'b1;
        idx          = pos_w;
      end
    end
  end

endmodule

// File: rtl/control_fifo_arb.sv
// Grants one byte source at a time for a whole 256-bit word, so FIFO words never mix sources.
module control_fifo_arb
  import control_fifo_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int BURST_BYTES     = BURST_BYTES_DEF,
  parameter int START_MAX_LEVEL = START_MAX_LEVEL_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  control_fifo_arb_if.slave  bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(BURST_BYTES);
  localparam logic [CW-1:0]      LAST_CNT  = CW'(BURST_BYTES - 1);
  localparam logic [LEVEL_W-1:0] START_LVL = LEVEL_W'(START_MAX_LEVEL);
  localparam logic [IW-1:0]      TOP_ID    = IW'(N_REQ - 1);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    grant_id;
  logic [N_REQ-1:0] grant_oh;
  logic [CW-1:0]    cnt;
  logic [7:0]       dout;
  logic             dout_vld;
  logic             busy;
  logic             burst_done;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] rdy;
  logic [7:0]       src_byte;
  logic             start;
  logic             accept;

  control_fifo_arb_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .grant  (pick_oh),
    .idx    (pick_idx)
  );

  assign start = bus.en && (|bus.req) && (bus.wr_water_level <= START_LVL) && !bus.almost_full;

  // almost_full must gate ready combinationally so no byte is taken into a full FIFO.
  assign rdy    = (state == BURST && !bus.almost_full) ? grant_oh : '0;
  assign accept = |(rdy & bus.src_vld);

  always_comb begin
    src_byte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant_oh[i]) src_byte = src_byte | bus.src_data[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      grant_id   <= '0;
      grant_oh   <= '0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      dout_vld   <= accept;
      burst_done <= accept && (cnt == LAST_CNT);
      if (accept) dout <= src_byte;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= BURST;
            busy     <= 1'b1;
            grant_id <= pick_idx;
            grant_oh <= pick_oh;
            cnt      <= '0;
          end
        end
        BURST: begin
          // Only accepted bytes advance the burst; req/vld/en changes are ignored here.
          if (accept) begin
            if (cnt == LAST_CNT) begin
              state  <= IDLE;
              busy   <= 1'b0;
              cnt    <= '0;
              rr_ptr <= (grant_id == TOP_ID) ? '0 : grant_id + IW'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.src_rdy    = rdy;
  assign bus.dout       = dout;
  assign bus.dout_vld   = dout_vld;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = busy;
  assign bus.burst_done = burst_done;

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rdy));
  a_no_wr_after_af: assert property (@(posedge clk) disable iff (!rst_n) bus.almost_full |=> !dout_vld);

endmodule

// File: tb/tb_control_fifo_arb.sv
// Scenario bench for control_fifo_arb: source models feed bytes, a scoreboard checks the FIFO write stream.
module tb_control_fifo_arb;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
    logic       done;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_fifo_arb_if #(.N_REQ(N)) bus ();

  control_fifo_arb #(.N_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int       n_cmp   = 0;
  int       n_err   = 0;
  int       af_viol = 0;
  ent_t     exp_q[$];
  ent_t     obs_q[$];
  logic [5:0] bp [N];
  logic [N-1:0] o_rdy;
  logic     o_busy, o_done;
  logic [1:0] o_gid;

  // Source i emits {i, running byte index}, advancing only on a handshake.
  task automatic drive_data();
    for (int i = 0; i < N; i++) bus.src_data[8*i +: 8] = {2'(i), bp[i]};
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    logic af;
    ent_t e;
    @(negedge clk);
    hs    = bus.src_vld & bus.src_rdy;
    o_rdy = bus.src_rdy;
    af    = bus.almost_full;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i] && rst_n) bp[i] = bp[i] + 6'd1;
    drive_data();
    if (af && bus.dout_vld) af_viol++;
    if (bus.dout_vld) begin
      e.gid = bus.grant_id; e.data = bus.dout; e.done = bus.burst_done;
      obs_q.push_back(e);
    end
    o_busy = bus.busy;
    o_done = bus.burst_done;
    o_gid  = bus.grant_id;
  endtask

  task automatic exp_burst(input int s, input int first, input int nbytes, input bit with_done);
    ent_t e;
    for (int j = 0; j < nbytes; j++) begin
      e.gid  = 2'(s);
      e.data = {2'(s), 6'(first + j)};
      e.done = with_done && (j == nbytes - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_inputs();
    bus.en = 1'b0; bus.req = '0; bus.src_vld = '0;
    bus.almost_full = 1'b0; bus.wr_water_level = '0;
    for (int i = 0; i < N; i++) bp[i] = '0;
    drive_data();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    rst_n = 1'b1;
    af_viol = 0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.en = 1'b1; bus.req = 4'b1111; bus.src_vld = 4'b1111;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", o_busy); end
    n_cmp++; if (bus.dout_vld !== 1'b0) begin n_err++; $display("FAIL reset dout_vld: got %b want 0", bus.dout_vld); end
    n_cmp++; if (bus.burst_done !== 1'b0) begin n_err++; $display("FAIL reset burst_done: got %b want 0", bus.burst_done); end
    n_cmp++; if (o_gid !== 2'd0) begin n_err++; $display("FAIL reset grant_id: got %0d want 0", o_gid); end
    n_cmp++; if (bus.dout !== 8'h00) begin n_err++; $display("FAIL reset dout: got %h want 00", bus.dout); end
    n_cmp++; if (o_rdy !== 4'b0000) begin n_err++; $display("FAIL reset src_rdy: got %b want 0000", o_rdy); end
    clear_inputs();
  endtask

  task automatic test_single();
    bit got = 0;
    ent_t o, e;
    apply_reset();
    exp_burst(0, 0, 32, 1);
    bus.en = 1'b1; bus.req = 4'b0001; bus.src_vld = 4'b0001;
    for (int t = 0; t < 100 && !got; t++) begin tick(); if (o_done) got = 1; end
    bus.req = '0; bus.src_vld = '0;
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL single done: got %b want 1", got); end
    n_cmp++; if (o_gid !== 2'd0) begin n_err++; $display("FAIL single grant_id: got %0d want 0", o_gid); end
    tick(); tick(); tick();
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL single idle busy: got %b want 0", o_busy); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL single sb: got g%0d %h d%b want g%0d %h d%b", o.gid, o.data, o.done, e.gid, e.data, e.done); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fairness();
    int bursts = 0;
    bit chk = 0;
    ent_t o, e;
    apply_reset();
    for (int k = 0; k < 8; k++) exp_burst(k % 4, (k / 4) * 32, 32, 1);
    bus.en = 1'b1; bus.req = 4'b1111; bus.src_vld = 4'b1111;
    for (int t = 0; t < 800 && bursts < 8; t++) begin
      tick();
      if (chk) begin
        chk = 0; n_cmp++;
        if (o_busy !== 1'b1 || o_gid !== 2'(bursts % 4)) begin
          n_err++; $display("FAIL fair regrant: got busy=%b gid=%0d want busy=1 gid=%0d", o_busy, o_gid, bursts % 4);
        end
      end
      if (o_done) begin
        bursts++; n_cmp++;
        if (o_busy !== 1'b0) begin n_err++; $display("FAIL fair bubble: got busy=%b want 0", o_busy); end
        chk = (bursts < 8);
        if (bursts == 8) begin bus.req = '0; bus.src_vld = '0; end
      end
    end
    n_cmp++; if (bursts != 8) begin n_err++; $display("FAIL fair bursts: got %0d want 8", bursts); end
    tick(); tick();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL fair count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL fair sb: got g%0d %h d%b want g%0d %h d%b", o.gid, o.data, o.done, e.gid, e.data, e.done); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    int cyc = -1, af_checks = 0;
    bit got = 0;
    ent_t o, e;
    apply_reset();
    exp_burst(0, 0, 32, 1);
    bus.en = 1'b1; bus.req = 4'b0001; bus.src_vld = 4'b0001;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (o_done) got = 1;
      if (bus.almost_full) begin
        af_checks++; n_cmp++;
        if (o_rdy !== 4'b0000) begin n_err++; $display("FAIL bp src_rdy: got %b want 0000", o_rdy); end
      end
      if (cyc >= 0) cyc++;
      else if (o_busy) cyc = 0;
      bus.almost_full = (cyc >= 10 && cyc <= 14);
    end
    bus.almost_full = 1'b0; bus.req = '0; bus.src_vld = '0;
    tick(); tick();
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL bp done: got %b want 1", got); end
    n_cmp++; if (af_checks != 5) begin n_err++; $display("FAIL bp af cycles: got %0d want 5", af_checks); end
    n_cmp++; if (af_viol != 0) begin n_err++; $display("FAIL bp write after af: got %0d want 0", af_viol); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bp sb: got g%0d %h d%b want g%0d %h d%b", o.gid, o.data, o.done, e.gid, e.data, e.done); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_level_gate();
    bit got = 0;
    ent_t o, e;
    apply_reset();
    exp_burst(1, 0, 32, 1);
    bus.en = 1'b1; bus.req = 4'b0010; bus.src_vld = 4'b0010;
    bus.wr_water_level = 11'd2017;
    repeat (4) tick();
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL level 2017 busy: got %b want 0", o_busy); end
    n_cmp++; if (o_rdy !== 4'b0000) begin n_err++; $display("FAIL level 2017 src_rdy: got %b want 0000", o_rdy); end
    bus.wr_water_level = 11'd2016;
    tick();
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL level 2016 busy: got %b want 1", o_busy); end
    n_cmp++; if (o_gid !== 2'd1) begin n_err++; $display("FAIL level 2016 grant_id: got %0d want 1", o_gid); end
    for (int t = 0; t < 100 && !got; t++) begin tick(); if (o_done) got = 1; end
    bus.req = '0; bus.src_vld = '0;
    tick(); tick();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL level count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL level sb: got g%0d %h d%b want g%0d %h d%b", o.gid, o.data, o.done, e.gid, e.data, e.done); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall_en();
    bit got = 0, stalled = 0;
    int left = 0;
    ent_t o, e;
    apply_reset();
    exp_burst(0, 0, 32, 1);
    bus.en = 1'b1; bus.req = 4'b0001; bus.src_vld = 4'b0001;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (o_done) got = 1;
      if (bp[0] == 6'd8 && !stalled) begin
        stalled = 1; left = 5; bus.src_vld = '0;
      end else if (left > 0) begin
        n_cmp++;
        if (o_busy !== 1'b1 || o_gid !== 2'd0) begin n_err++; $display("FAIL stall hold: got busy=%b gid=%0d want busy=1 gid=0", o_busy, o_gid); end
        left--;
        if (left == 0) bus.src_vld = 4'b0001;
      end
      if (bp[0] == 6'd12) begin bus.en = 1'b0; bus.req = '0; end
    end
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL stall done: got %b want 1", got); end
    bus.req = 4'b0001;
    for (int t = 0; t < 5; t++) begin
      tick(); n_cmp++;
      if (o_busy !== 1'b0 || o_rdy !== 4'b0000) begin n_err++; $display("FAIL en low idle: got busy=%b rdy=%b want busy=0 rdy=0000", o_busy, o_rdy); end
    end
    bus.req = '0; bus.src_vld = '0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL stall sb: got g%0d %h d%b want g%0d %h d%b", o.gid, o.data, o.done, e.gid, e.data, e.done); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    bit got = 0, seen = 0;
    ent_t o, e;
    apply_reset();
    exp_burst(0, 0, 17, 0);
    exp_burst(2, 0, 32, 1);
    bus.en = 1'b1; bus.req = 4'b0001; bus.src_vld = 4'b0001;
    for (int t = 0; t < 100 && bp[0] != 6'd17; t++) tick();
    rst_n = 1'b0;
    bus.req = 4'b0100; bus.src_vld = 4'b0100;
    tick();
    n_cmp++; if (bus.dout_vld !== 1'b0) begin n_err++; $display("FAIL rstmid dout_vld: got %b want 0", bus.dout_vld); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.burst_done !== 1'b0) begin n_err++; $display("FAIL rstmid burst_done: got %b want 0", bus.burst_done); end
    n_cmp++; if (bus.grant_id !== 2'd0) begin n_err++; $display("FAIL rstmid grant_id: got %0d want 0", bus.grant_id); end
    n_cmp++; if (bus.dout !== 8'h00) begin n_err++; $display("FAIL rstmid dout: got %h want 00", bus.dout); end
    n_cmp++; if (bus.src_rdy !== 4'b0000) begin n_err++; $display("FAIL rstmid src_rdy: got %b want 0000", bus.src_rdy); end
    for (int i = 0; i < N; i++) bp[i] = '0;
    drive_data();
    rst_n = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      tick();
      if (o_busy && !seen) begin
        seen = 1; n_cmp++;
        if (o_gid !== 2'd2) begin n_err++; $display("FAIL rstmid regrant: got %0d want 2", o_gid); end
      end
      if (o_done) got = 1;
    end
    bus.req = '0; bus.src_vld = '0;
    tick(); tick();
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL rstmid done: got %b want 1", got); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rstmid sb: got g%0d %h d%b want g%0d %h d%b", o.gid, o.data, o.done, e.gid, e.data, e.done); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_level_gate();
    test_stall_en();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
